// File: rtl/sseg_pkg.sv
// Shared types and segment patterns for the seven-segment scan driver.
// Segment patterns are active-low, bit order g..a (bit 6 = g, bit 0 = a).
package sseg_pkg;

   typedef logic [3:0] bcd_t;
   typedef logic [6:0] seg_t;

   localparam int NUM_DIGITS = 8;

   localparam seg_t SEG_BLANK = 7'h7F;
   localparam seg_t SEG_DASH  = 7'h3F;

   localparam seg_t SEG_0 = 7'b1000000;
   localparam seg_t SEG_1 = 7'b1111001;
   localparam seg_t SEG_2 = 7'b0100100;
   localparam seg_t SEG_3 = 7'b0110000;
   localparam seg_t SEG_4 = 7'b0011001;
   localparam seg_t SEG_5 = 7'b0010010;
   localparam seg_t SEG_6 = 7'b0000010;
   localparam seg_t SEG_7 = 7'b1111000;
   localparam seg_t SEG_8 = 7'b0000000;
   localparam seg_t SEG_9 = 7'b0010000;

   // Active-low one-hot anode vector for a digit slot.
   function automatic logic [NUM_DIGITS-1:0] anode_sel(input logic [2:0] slot);
      anode_sel = ~(8'h01 << slot);
   endfunction

endpackage

// File: rtl/sseg_scan_driver_if.sv
// Digit/display bundle between the stopwatch counter and the scan driver.
// master: the digit source (drives digits and blanking enable).
// slave : the scan driver (drives anodes and segments).
interface sseg_scan_driver_if;
   import sseg_pkg::*;

   logic lzb_en;
   bcd_t d7, d6, d5, d4, d3, d2, d1, d0;
   logic [NUM_DIGITS-1:0] an;
   logic [7:0]            sseg;

   modport master (
      output lzb_en, d7, d6, d5, d4, d3, d2, d1, d0,
      input  an, sseg
   );

   modport slave (
      input  lzb_en, d7, d6, d5, d4, d3, d2, d1, d0,
      output an, sseg
   );

endinterface

// File: rtl/sseg_scan_driver_bcd_to_sseg.sv
// Combinational BCD to seven-segment decoder (active-low, g..a).
// Codes 10-15 are not valid BCD and show a dash so bad data is visible.
module bcd_to_sseg
   import sseg_pkg::*;
(
   input  bcd_t i_bcd,
   output seg_t o_seg
);

   // Pattern lookup; anything outside 0-9 falls through to the dash.
   always_comb begin
      o_seg = SEG_DASH;
      case (i_bcd)
         4'd0:    o_seg = SEG_0;
         4'd1:    o_seg = SEG_1;
         4'd2:    o_seg = SEG_2;
         4'd3:    o_seg = SEG_3;
         4'd4:    o_seg = SEG_4;
         4'd5:    o_seg = SEG_5;
         4'd6:    o_seg = SEG_6;
         4'd7:    o_seg = SEG_7;
         4'd8:    o_seg = SEG_8;
         4'd9:    o_seg = SEG_9;
         default: o_seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/sseg_scan_driver.sv
// Eight-digit common-anode scan driver for the HH:MM:SS.cc stopwatch.
// One digit per slot of REFRESH_DIV cycles; the first BLANK_CYCLES of each
// slot are dead time (all anodes off) to stop ghosting between digits.
// Digits are snapshotted once per frame so a frame never mixes old and new
// time values. Outputs are registered: one cycle from (slot, count, snapshot).
module sseg_scan_driver
   import sseg_pkg::*;
#(
   parameter int         REFRESH_DIV  = 2**17,
   parameter int         BLANK_CYCLES = 64,
   parameter logic [7:0] DP_MASK      = 8'b0101_0100,
   parameter int         LZB_MIN      = 2
)(
   input  logic               clk,
   input  logic               rst,
   sseg_scan_driver_if.slave  bus
);

   localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
   localparam logic [2:0]       LZB_IDX   = 3'(LZB_MIN);

   generate
      if (BLANK_CYCLES < 0 || BLANK_CYCLES >= REFRESH_DIV || REFRESH_DIV < 2) begin : g_bad_param
         $error("sseg_scan_driver: need 0 <= BLANK_CYCLES < REFRESH_DIV and REFRESH_DIV >= 2");
      end
   endgenerate

   logic [CNT_W-1:0]            r_count;
   logic [2:0]                  r_slot;
   bcd_t [NUM_DIGITS-1:0]       r_snap;
   logic                        r_cap_pend;
   logic [NUM_DIGITS-1:0]       r_an;
   logic [7:0]                  r_sseg;

   bcd_t [NUM_DIGITS-1:0]       w_in_digits;
   logic                        w_slot_end;
   logic                        w_frame_end;
   logic                        w_active;
   logic [NUM_DIGITS-1:0]       w_zero;
   logic [NUM_DIGITS-1:0]       w_zero_up;
   logic                        w_blank;
   bcd_t                        w_digit;
   seg_t                        w_seg;

   assign w_in_digits = {bus.d7, bus.d6, bus.d5, bus.d4,
                         bus.d3, bus.d2, bus.d1, bus.d0};

   assign w_slot_end  = (r_count == CNT_MAX);
   assign w_frame_end = w_slot_end && (r_slot == 3'd7);
   assign w_active    = (r_count >= CNT_BLANK);

   // Free-running slot timer: count within the slot, slot wraps 7 -> 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
         r_slot  <= '0;
      end else if (w_slot_end) begin
         r_count <= '0;
         r_slot  <= r_slot + 3'd1;
      end else begin
         r_count <= r_count + 1'b1;
      end
   end

   // Frame snapshot: taken on the last cycle of slot 7 and once right after
   // reset releases, so the first frame does not show the reset zeros.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_snap     <= '0;
         r_cap_pend <= 1'b1;
      end else begin
         r_cap_pend <= 1'b0;
         if (r_cap_pend || w_frame_end)
            r_snap <= w_in_digits;
      end
   end

   // Leading-zero detect: w_zero_up[i] is set when digits i..7 are all zero.
   always_comb begin
      w_zero    = '0;
      w_zero_up = '0;
      for (int i = 0; i < NUM_DIGITS; i++)
         w_zero[i] = (r_snap[i] == 4'd0);
      w_zero_up[NUM_DIGITS-1] = w_zero[NUM_DIGITS-1];
      for (int i = NUM_DIGITS-2; i >= 0; i--)
         w_zero_up[i] = w_zero[i] & w_zero_up[i+1];
   end

   // Digits above LZB_MIN blank out (anode and DP) while they lead with zeros.
   assign w_blank = bus.lzb_en && (r_slot > LZB_IDX) && w_zero_up[r_slot];

   assign w_digit = r_snap[r_slot];

   bcd_to_sseg u_dec (
      .i_bcd (w_digit),
      .o_seg (w_seg)
   );

   // Output register: dead time and blanked digits drive everything off.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_an   <= 8'hFF;
         r_sseg <= 8'hFF;
      end else if (!w_active || w_blank) begin
         r_an   <= 8'hFF;
         r_sseg <= 8'hFF;
      end else begin
         r_an   <= anode_sel(r_slot);
         r_sseg <= {~DP_MASK[r_slot], w_seg};
      end
   end

   assign bus.an   = r_an;
   assign bus.sseg = r_sseg;

endmodule

// File: doc/sseg_scan_driver.md
Name: sseg_scan_driver

Overview:
- Downstream consumer of the stopwatch 8-digit BCD counter outputs d7..d0, laid out HH:MM:SS.cc.
- Time-multiplexes the digits onto a common-anode 8-digit seven-segment display.
- Snapshots digits once per frame to prevent tearing. Provides leading-zero blanking, fixed decimal points and an anti-ghosting dead time between digits.

Parameters:
- REFRESH_DIV, 2**17, clk cycles per digit slot (100 MHz gives ~763 Hz/digit, ~95 Hz frame).
- BLANK_CYCLES, 64, cycles at the start of each slot with all anodes off. Must satisfy 0 <= BLANK_CYCLES < REFRESH_DIV; an elaboration-time assertion enforces this.
- DP_MASK, 8'b0101_0100, bit i set lights the DP on digit i (d6, d4, d2 by default).
- LZB_MIN, 2, highest digit index that is never blanked (always shows "0.00").

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- lzb_en  in  1  leading-zero blanking enable
- d7..d0  in  4 each  BCD digits; d0 is least significant
- an  out  8  anode enables, active-low; an[i] drives digit i
- sseg  out  8  segments, active-low; [7]=dp, [6:0]=g..a

Behaviour:
- Reset values: an=8'hFF, sseg=8'hFF, slot=0, count=0, snapshot=all zero.
- Slot counter:
  - count runs 0..REFRESH_DIV-1.
  - When count=REFRESH_DIV-1, count wraps to 0 and slot increments mod 8 (7 -> 0).
  - Counting is free-running; there is no enable.
- Snapshot:
  - All eight digits are captured into an internal register on the cycle where count=REFRESH_DIV-1 and slot=7, so the new frame starts with fresh data.
  - Also captured on the first cycle after rst deasserts.
  - Inputs are never sampled at any other time.
- Active window: digit slot is driven only while count >= BLANK_CYCLES. Otherwise an=8'hFF and sseg=8'hFF (dead time).
- Output timing: an and sseg are registered from the current (slot, count, snapshot), so there is one cycle of latency. No combinational path runs from inputs to outputs.
- Decode, per snapshot digit:
  - 0-9 map to standard patterns (e.g. 0 -> 7'b1000000, 8 -> 7'b0000000).
  - 10-15 map to "-" (7'b0111111).
  - dp (sseg[7]) = ~DP_MASK[slot].
- Leading-zero blanking:
  - Applies only when lzb_en=1.
  - Digit i with i > LZB_MIN is blanked if snapshot digits i..7 are all zero.
  - A blanked digit keeps its anode high for the entire slot, and its DP is suppressed.
  - Digits at or below LZB_MIN always display.
- Simultaneous events: rst takes priority over slot advance and snapshot capture.
- Reset mid-frame: outputs go to 8'hFF on the next edge, and scanning restarts at slot 0.
- Each slot's duty is (REFRESH_DIV-BLANK_CYCLES)/REFRESH_DIV. At most one an bit is low in any cycle.

Decomposition:
- Package sseg_pkg holds:
  - typedef bcd_t (logic [3:0]);
  - typedef seg_t (logic [6:0]);
  - constants SEG_BLANK=7'h7F and SEG_DASH=7'h3F;
  - digit pattern constants SEG_0..SEG_9.
- One combinational sub-module, bcd_to_sseg (bcd_t in, seg_t out), instantiated once on the muxed digit.
- Scan counter, snapshot, blanking logic and output registers stay in sseg_scan_driver.

Test Plan:
All scenarios use REFRESH_DIV=16, BLANK_CYCLES=2.
- Reset and timing: rst high 3 cycles then low, with digits 8'h0000_0123 presented. Required: an=8'hFF for the first 2 edges. an=8'hFE from the 3rd edge for 14 cycles. sseg[6:0] = SEG_3, sseg[7]=1. Next slot gives an=8'hFD with SEG_2.
- Full frame, lzb_en=0, digits 1,2,3,4,5,6,7,8 (d7..d0). Required, in slot order 0..7:
  - an walks FE, FD, FB, F7, EF, DF, BF, 7F;
  - segments show 8,7,6,5,4,3,2,1;
  - dp is low only in slots 2, 4 and 6;
  - at most one an bit is low in any cycle.
- Blanking, lzb_en=1, digits all zero. Required: slots 3-7 keep an=8'hFF throughout. Slots 0-2 show 0, with dp low on slot 2. With d4=1: slots 3 and 4 are driven, slots 5-7 stay blanked.
- Tearing: change d0 from 3 to 4 mid-frame (slot 4). Required: slot 0 keeps showing SEG_3 until the next frame, and SEG_4 appears only in the following frame's slot 0.
- Invalid BCD: d1=4'hC. Required: slot 1 sseg[6:0]=7'b0111111 ("-").
- Reset mid-slot 5: rst pulse for 1 cycle. Required: an=8'hFF and sseg=8'hFF on the next edge, then scanning resumes at slot 0 after BLANK_CYCLES+1 edges.
